sixteen_to_four_encoder: RTL and testbench
==========================================

# sixteen_to_four_encoder

- Sequential 16-to-4 priority encoder: the inverse direction of the board's 4-to-16 decoder path.
- Samples 16 raw input lines plus an enable from the Nexys board switches/buttons, then synchronizes and debounces them.
- Registers a 4-bit index with valid and multiple-hot flags.
- Reports every change of the encoded result to downstream logic through a valid/ready event handshake.
- Sits between board inputs and the lab's display/controller logic.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive cycles the synchronized inputs must hold before being accepted; legal range 1 to 2^24.
- CLK100MHZ  input  1  system clock; all flops clock on the rising edge.
- CPU_RESETN  input  1  asynchronous, active-low reset.
- y_in  input  16  raw input lines; bit i asserted means "line i active".
- En  input  1  raw encoder enable, active high.
- code  output  4  index of highest active line.
- valid  output  1  En high and at least one line active.
- multi  output  1  En high and more than one line active.
- evt_valid  output  1  event pending.
- evt_code  output  4  event payload: code.
- evt_hit  output  1  event payload: valid.
- evt_multi  output  1  event payload: multi.
- evt_ready  input  1  consumer accepts the event.
- ovf  output  1  sticky flag: an intermediate result was never reported.

## Operation
- **Synchronizer:** {En, y_in} (17 bits) pass through a 2-flop synchronizer; output is `s`.
- **Debounce:**
  - A counter of width $clog2(DEBOUNCE_CYCLES+1) resets to 0 whenever `s` differs from its previous-cycle value; otherwise it increments, saturating.
  - When `s` has been unchanged for DEBOUNCE_CYCLES consecutive edges, `s` is loaded into the stable vector `d`.
  - Any glitch shorter than DEBOUNCE_CYCLES never reaches `d`.
- **Encoder (registered from `d`):**
  - Enable low: valid=0, multi=0, code=0, regardless of lines.
  - Enable high, no line set: valid=0, multi=0, code=0.
  - Enable high, lines set: code = highest set index (bit 15 has highest priority), valid=1, multi=1 if popcount > 1.
- **Event FSM, states IDLE and PEND:**
  - A `last` register holds the most recently reported {valid, multi, code}.
  - IDLE: if the current {valid, multi, code} differs from `last`, load the evt_* payload and `last`, then go to PEND.
  - PEND: evt_valid=1 and the payload is held stable. If the encoder result changes again while in PEND, set ovf=1 and leave the payload untouched.
  - PEND with evt_ready=1: handshake completes; go to IDLE.
  - After the handshake, IDLE compares again. If the result differs from `last`, a new event is presented one cycle later. Only the latest value is reported; intermediate values are lost.
- evt_ready while in IDLE is ignored.
- ovf clears only on reset.

## Timing
- Reset (CPU_RESETN low, asynchronous):
  - Outputs: code=0, valid=0, multi=0, evt_valid=0, evt_code=0, evt_hit=0, evt_multi=0, ovf=0.
  - Internal: synchronizer=0, d=0, counter=0, last=0, FSM=IDLE.
  - Consequence: an all-zero input after reset produces no event.
- Reset release: deassertion is assumed synchronous to CLK100MHZ at the board level; the block adds no reset synchronizer.
- Latency, with inputs changing before edge 0 and then held:
  - `s` updates at edge 2.
  - `d` updates at edge 2+DEBOUNCE_CYCLES.
  - code/valid/multi update at edge 3+DEBOUNCE_CYCLES.
  - evt_valid rises at edge 4+DEBOUNCE_CYCLES if the FSM is in IDLE.
- Handshake: an event transfers on an edge where evt_valid=1 and evt_ready=1. evt_valid drops on that same edge unless a new difference exists; the earliest re-assertion is the following edge.
- Simultaneous events:
  - A result change on the handshake edge is not an overflow; it is reported by the next IDLE compare.
  - A change while in PEND without handshake sets ovf.
- Reset mid-PEND: evt_valid drops immediately and the pending event is discarded.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and evt_ready=1 unless stated.
- Assert reset, then release with all inputs 0 and run 20 cycles -> all outputs 0; evt_valid never asserts.
- En=1, y_in=16'h0020 held -> code=5, valid=1, multi=0 at edge 7; evt_valid=1 at edge 8 with evt_code=5, evt_hit=1; evt_valid low at edge 9.
- y_in=16'h8001, En=1 -> code=15, multi=1, one event with evt_multi=1.
- Bit 3 toggles every 2 cycles for 20 cycles, then holds 16'h0008 -> code/valid never change during toggling; exactly one event, evt_code=3.
- evt_ready=0; inputs go 16'h0002, then 16'h0010 after stabilization -> payload stays code=1, ovf=1; with evt_ready=1, event code=1 transfers, then event code=4 follows.
- En=0, y_in=16'h0F00 -> valid=0, code=0, no event. Then pulse CPU_RESETN low mid-PEND -> evt_valid=0 and ovf=0 within the same cycle.

Source files
------------

// File: rtl/sixteen_to_four_encoder.sv
// Debounced 16-to-4 priority encoder for board inputs. Every change of the
// registered result is presented once on a valid/ready event port.
module sixteen_to_four_encoder #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [15:0] y_in,
  input  logic        En,
  output logic [3:0]  code,
  output logic        valid,
  output logic        multi,
  output logic        evt_valid,
  output logic [3:0]  evt_code,
  output logic        evt_hit,
  output logic        evt_multi,
  input  logic        evt_ready,
  output logic        ovf
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

  typedef struct packed {
    logic       hit;
    logic       multi;
    logic [3:0] code;
  } res_t;

  typedef enum logic {IDLE, PEND} st_t;

  logic [16:0]   s1_q, s_q, d_q;
  logic [CW-1:0] cnt_q;
  res_t          enc_d, enc_q, last_q;
  st_t           st_q, st_d;
  logic          load, ovf_set, ovf_q;

  // The counter tracks how long s_q has held; s1_q != s_q means s_q changes
  // on this edge, so d_q is loaded exactly DEBOUNCE_CYCLES edges after s_q.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      s1_q  <= '0;
      s_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
    end else begin
      s1_q <= {En, y_in};
      s_q  <= s1_q;
      if (s1_q != s_q)
        cnt_q <= '0;
      else if (cnt_q != CNT_MAX)
        cnt_q <= cnt_q + 1'b1;
      if (s1_q == s_q && cnt_q >= CNT_LOAD)
        d_q <= s_q;
    end
  end

  always_comb begin
    enc_d = '0;
    if (d_q[16]) begin
      for (int i = 0; i < 16; i++)
        if (d_q[i]) enc_d.code = 4'(i);
      enc_d.hit   = |d_q[15:0];
      enc_d.multi = |(d_q[15:0] & (d_q[15:0] - 16'd1));
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) enc_q <= '0;
    else             enc_q <= enc_d;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) st_q <= IDLE;
    else             st_q <= st_d;
  end

  always_comb begin
    st_d    = st_q;
    load    = 1'b0;
    ovf_set = 1'b0;
    case (st_q)
      IDLE: if (enc_q != last_q) begin
        st_d = PEND;
        load = 1'b1;
      end
      PEND: if (evt_ready) st_d = IDLE;
            else if (enc_q != last_q) ovf_set = 1'b1;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    evt_valid = (st_q == PEND);
  end

  // The reported payload and the last-reported value are always the same
  // word, so one register serves as both.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      last_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (load)    last_q <= enc_q;
      if (ovf_set) ovf_q  <= 1'b1;
    end
  end

  assign code      = enc_q.code;
  assign valid     = enc_q.hit;
  assign multi     = enc_q.multi;
  assign evt_code  = last_q.code;
  assign evt_hit   = last_q.hit;
  assign evt_multi = last_q.multi;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sixteen_to_four_encoder.sv
// Directed bench for sixteen_to_four_encoder with DEBOUNCE_CYCLES=4.
module tb_sixteen_to_four_encoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] y;
  logic        en;
  logic        rdy;
  logic [3:0]  code, evt_code;
  logic        valid, multi, evt_valid, evt_hit, evt_multi, ovf;

  int n_cmp = 0;
  int n_err = 0;

  sixteen_to_four_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .y_in      (y),
    .En        (en),
    .code      (code),
    .valid     (valid),
    .multi     (multi),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_hit   (evt_hit),
    .evt_multi (evt_multi),
    .evt_ready (rdy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0; y = '0; en = 1'b0; rdy = 1'b1;
    #23;
    n_cmp++;
    if ({code, valid, multi, evt_valid, evt_code, evt_hit, evt_multi, ovf} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_outputs got code=%0d v=%0b m=%0b ev=%0b ec=%0d eh=%0b em=%0b ovf=%0b want all 0",
               code, valid, multi, evt_valid, evt_code, evt_hit, evt_multi, ovf);
    end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (evt_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL reset_no_event got %0d event cycles want 0", seen);
    end
    n_cmp++;
    if ({code, valid, multi, ovf} !== 7'd0) begin
      n_err++;
      $display("FAIL reset_idle got code=%0d v=%0b m=%0b ovf=%0b want 0", code, valid, multi, ovf);
    end
  endtask

  task automatic test_single();
    en = 1'b1; y = 16'h0020; rdy = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    n_cmp++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_latency_e6 got valid=%0b want 0", valid);
    end
    tick();
    n_cmp++;
    if ({code, valid, multi, evt_valid} !== {4'd5, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL single_e7 got code=%0d v=%0b m=%0b ev=%0b want 5 1 0 0", code, valid, multi, evt_valid);
    end
    tick();
    n_cmp++;
    if ({evt_valid, evt_code, evt_hit, evt_multi} !== {1'b1, 4'd5, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL single_e8 got ev=%0b ec=%0d eh=%0b em=%0b want 1 5 1 0", evt_valid, evt_code, evt_hit, evt_multi);
    end
    tick();
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_e9 got ev=%0b want 0", evt_valid);
    end
  endtask

  task automatic test_multi();
    int seen;
    logic [3:0] ec;
    logic em;
    seen = 0; ec = '0; em = 1'b0;
    y = 16'h8001;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (evt_valid) begin seen++; ec = evt_code; em = evt_multi; end
    end
    n_cmp++;
    if ({code, valid, multi} !== {4'd15, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL multi_result got code=%0d v=%0b m=%0b want 15 1 1", code, valid, multi);
    end
    n_cmp++;
    if ({seen[3:0], ec, em} !== {4'd1, 4'd15, 1'b1}) begin
      n_err++;
      $display("FAIL multi_event got count=%0d ec=%0d em=%0b want 1 15 1", seen, ec, em);
    end
  endtask

  task automatic test_glitch();
    int seen, bad;
    logic [3:0] ec;
    seen = 0; bad = 0; ec = '0;
    for (int i = 0; i < 5; i++) begin
      y = 16'h0008;
      for (int k = 0; k < 4; k++) begin
        if (k == 2) y = 16'h0000;
        tick();
        if (code !== 4'd15 || valid !== 1'b1) bad++;
        if (evt_valid) begin seen++; ec = evt_code; end
      end
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL glitch_filtered got %0d disturbed cycles want 0", bad);
    end
    y = 16'h0008;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (evt_valid) begin seen++; ec = evt_code; end
    end
    n_cmp++;
    if ({seen[3:0], ec, code} !== {4'd1, 4'd3, 4'd3}) begin
      n_err++;
      $display("FAIL glitch_event got count=%0d ec=%0d code=%0d want 1 3 3", seen, ec, code);
    end
  endtask

  task automatic test_overflow();
    rdy = 1'b0; y = 16'h0002;
    for (int i = 0; i < 10; i++) tick();
    n_cmp++;
    if ({evt_valid, evt_code, ovf} !== {1'b1, 4'd1, 1'b0}) begin
      n_err++;
      $display("FAIL ovf_first got ev=%0b ec=%0d ovf=%0b want 1 1 0", evt_valid, evt_code, ovf);
    end
    y = 16'h0010;
    for (int i = 0; i < 10; i++) tick();
    n_cmp++;
    if ({evt_valid, evt_code, ovf, code} !== {1'b1, 4'd1, 1'b1, 4'd4}) begin
      n_err++;
      $display("FAIL ovf_held got ev=%0b ec=%0d ovf=%0b code=%0d want 1 1 1 4", evt_valid, evt_code, ovf, code);
    end
    rdy = 1'b1;
    tick();
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_handshake got ev=%0b want 0", evt_valid);
    end
    tick();
    n_cmp++;
    if ({evt_valid, evt_code, ovf} !== {1'b1, 4'd4, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_second got ev=%0b ec=%0d ovf=%0b want 1 4 1", evt_valid, evt_code, ovf);
    end
    tick();
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_drain got ev=%0b want 0", evt_valid);
    end
  endtask

  task automatic test_disable_and_reset();
    int seen, waited;
    rst_n = 1'b0; rdy = 1'b1; en = 1'b0; y = 16'h0F00;
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (evt_valid) seen++;
    end
    n_cmp++;
    if ({code, valid, multi, seen[3:0]} !== 10'd0) begin
      n_err++;
      $display("FAIL disabled got code=%0d v=%0b m=%0b events=%0d want 0 0 0 0", code, valid, multi, seen);
    end
    rdy = 1'b0; en = 1'b1;
    waited = 0;
    while (evt_valid !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    n_cmp++;
    if ({evt_valid, evt_code, evt_multi} !== {1'b1, 4'd11, 1'b1}) begin
      n_err++;
      $display("FAIL enable_event got ev=%0b ec=%0d em=%0b after %0d cycles want 1 11 1", evt_valid, evt_code, evt_multi, waited);
    end
    y = 16'h0100;
    for (int i = 0; i < 10; i++) tick();
    n_cmp++;
    if ({evt_valid, ovf} !== 2'b11) begin
      n_err++;
      $display("FAIL pend_ovf got ev=%0b ovf=%0b want 1 1", evt_valid, ovf);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({evt_valid, ovf, code, valid} !== 7'd0) begin
      n_err++;
      $display("FAIL async_reset got ev=%0b ovf=%0b code=%0d v=%0b want 0 0 0 0", evt_valid, ovf, code, valid);
    end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_glitch();
    test_overflow();
    test_disable_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
